// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN engine pooling datapaths.
//   DW / AW      : data and memory address widths
//   SEL_*        : csel codes for the layer memories
//   pool_state_t : pooling sequencer states
//   ROUND_ADD    : half-LSB added before the divide-by-4 of a 2x2 average
package cnn_pkg;

   localparam int unsigned DW        = 20;
   localparam int unsigned AW        = 12;

   localparam logic [2:0]  SEL_NONE  = 3'b000;
   localparam logic [2:0]  SEL_L0    = 3'b001;
   localparam logic [2:0]  SEL_L1    = 3'b011;
   localparam logic [2:0]  SEL_L2    = 3'b101;

   localparam int unsigned ROUND_ADD = 2;
   localparam int unsigned AVG_SHIFT = 2;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      LAST = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } pool_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// 2x2 stride-2 pooling address generator (purely combinational).
//   o         : output pixel index, row-major over the (IN_DIM/2)^2 map
//   cnt       : window tap 0..3 -> offsets +0, +1, +IN_DIM, +IN_DIM+1
//   rd_addr_c : input-map address of the selected tap
//   wr_addr_c : output-map address of pixel o
module pool_addr_gen #(
   parameter int unsigned AW     = 12,
   parameter int unsigned IN_DIM = 32,
   parameter int unsigned OW     = 8
) (
   input  logic [OW-1:0] o,
   input  logic [1:0]    cnt,
   output logic [AW-1:0] rd_addr_c,
   output logic [AW-1:0] wr_addr_c
);
   import cnn_pkg::*;

   localparam int unsigned OUT_DIM = IN_DIM / 2;

   int unsigned row;
   int unsigned col;

   // Window base is (2*row)*IN_DIM + 2*col; cnt[1] picks the lower row, cnt[0] the right column.
   always_comb begin
      row       = 32'(o) / OUT_DIM;
      col       = 32'(o) % OUT_DIM;
      rd_addr_c = AW'((2 * row + 32'(cnt[1])) * IN_DIM + 2 * col + 32'(cnt[0]));
      wr_addr_c = AW'(o);
   end

endmodule

// File: rtl/avg_pool_l2.sv
// Layer-2 2x2 stride-2 average pool with round-half-up.
// Reads the IN_DIM x IN_DIM layer-1 map and writes the (IN_DIM/2)^2 layer-2 map row-major.
//   clk, reset (async, active-low)
//   start    : one-cycle request, honoured only in IDLE
//   busy     : high while the run is in progress
//   done     : one-cycle pulse after the last write
//   csel     : memory select (SEL_L1 while reading, SEL_L2 while writing)
//   crd      : read strobe,  caddr_rd : read address,  cdata_rd : read data (1-cycle latency)
//   cwr      : write strobe, caddr_wr : write address, cdata_wr : write data
module avg_pool_l2 #(
   parameter int unsigned DW     = cnn_pkg::DW,
   parameter int unsigned AW     = cnn_pkg::AW,
   parameter int unsigned IN_DIM = 32,
   parameter logic [2:0]  SEL_L1 = cnn_pkg::SEL_L1,
   parameter logic [2:0]  SEL_L2 = cnn_pkg::SEL_L2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [2:0]    csel,
   output logic          crd,
   output logic [AW-1:0] caddr_rd,
   input  logic [DW-1:0] cdata_rd,
   output logic          cwr,
   output logic [AW-1:0] caddr_wr,
   output logic [DW-1:0] cdata_wr
);
   import cnn_pkg::*;

   localparam int unsigned ACC_W  = DW + 2;
   localparam int unsigned OUT_N  = (IN_DIM / 2) * (IN_DIM / 2);
   localparam int unsigned OW     = $clog2(OUT_N);
   localparam logic [OW-1:0] O_LAST = OW'(OUT_N - 1);

   pool_state_t      state, state_d;
   logic [OW-1:0]    o, o_d;
   logic [1:0]       cnt, cnt_d;
   logic [ACC_W-1:0] acc, acc_d;

   logic             busy_d, done_d, crd_d, cwr_d;
   logic [2:0]       csel_d;
   logic [AW-1:0]    caddr_rd_d, caddr_wr_d;
   logic [DW-1:0]    cdata_wr_d;
   logic [AW-1:0]    rd_addr_c, wr_addr_c;

   // Addresses are generated from the next-cycle indices so they register alongside the strobes.
   pool_addr_gen #(
      .AW     (AW),
      .IN_DIM (IN_DIM),
      .OW     (OW)
   ) u_addr_gen (
      .o         (o_d),
      .cnt       (cnt_d),
      .rd_addr_c (rd_addr_c),
      .wr_addr_c (wr_addr_c)
   );

   // Next-state, accumulator and next-output decode.
   always_comb begin
      state_d = state;
      o_d     = o;
      cnt_d   = cnt;
      acc_d   = acc;

      unique case (state)
         IDLE: begin
            if (start) begin
               o_d     = '0;
               cnt_d   = '0;
               state_d = RD;
            end
         end
         RD: begin
            cnt_d = cnt + 2'd1;
            // Data of tap cnt-1 arrives this cycle; tap 0's cycle clears the window sum.
            acc_d = (cnt == 2'd0) ? '0 : acc + ACC_W'(cdata_rd);
            if (cnt == 2'd3) begin
               state_d = LAST;
            end
         end
         LAST: begin
            acc_d   = acc + ACC_W'(cdata_rd);
            state_d = WR;
         end
         WR: begin
            if (o == O_LAST) begin
               state_d = DONE;
            end else begin
               o_d     = o + OW'(1);
               cnt_d   = '0;
               state_d = RD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d     = (state_d == RD) || (state_d == LAST) || (state_d == WR);
      done_d     = (state_d == DONE);
      crd_d      = (state_d == RD);
      cwr_d      = (state_d == WR);
      csel_d     = crd_d ? SEL_L1 : (cwr_d ? SEL_L2 : SEL_NONE);
      caddr_rd_d = crd_d ? rd_addr_c : '0;
      caddr_wr_d = cwr_d ? wr_addr_c : '0;
      // Sum of four DW-bit taps plus 2 fits ACC_W bits, so the result never wraps.
      cdata_wr_d = cwr_d ? DW'((acc_d + ACC_W'(ROUND_ADD)) >> AVG_SHIFT) : '0;
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         o        <= '0;
         cnt      <= '0;
         acc      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         crd      <= 1'b0;
         cwr      <= 1'b0;
         csel     <= SEL_NONE;
         caddr_rd <= '0;
         caddr_wr <= '0;
         cdata_wr <= '0;
      end else begin
         state    <= state_d;
         o        <= o_d;
         cnt      <= cnt_d;
         acc      <= acc_d;
         busy     <= busy_d;
         done     <= done_d;
         crd      <= crd_d;
         cwr      <= cwr_d;
         csel     <= csel_d;
         caddr_rd <= caddr_rd_d;
         caddr_wr <= caddr_wr_d;
         cdata_wr <= cdata_wr_d;
      end
   end

endmodule
